// File: rtl/lutram_readback_checker.sv
// lutram_readback_checker
// Receive-side checker for the LUTRAM primitive test harnesses. It consumes the
// serial read-back stream (one bit per address, ascending) produced during the
// READ sweep and compares each bit against the written pattern addr[0]^INVERT.
// It counts mismatches (saturating), captures the first failing address, and
// reports pass/fail.
//
// Optional feature: define LUTRAM_CHK_TIMEOUT_EN to enable a watchdog. If
// TIMEOUT cycles pass in CHECK without a sample, the sweep aborts to FAIL and
// timeout_o is raised. When the macro is not defined, timeout_o is tied to 0.
//
// Ports:
//   clk_i             check clock (harness divided clock)
//   rst_ni            asynchronous active-low reset
//   start_i           begin a sweep (level or pulse), honoured in IDLE/PASS/FAIL
//   sample_i          q_i is valid for the current address this cycle
//   q_i               read-back data bit
//   busy_o            high while in CHECK
//   done_o            high while in PASS or FAIL
//   pass_o            high only in PASS
//   err_count_o       saturating mismatch count for the current/last sweep
//   first_err_addr_o  address of the first mismatch
//   first_err_valid_o first_err_addr_o is meaningful
//   timeout_o         sweep aborted by watchdog
module lutram_readback_checker #(
    parameter int unsigned A_WIDTH = 7,
    parameter int unsigned ERR_W   = 8,
    parameter logic        INVERT  = 1'b0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               sample_i,
    input  logic               q_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [ERR_W-1:0]   err_count_o,
    output logic [A_WIDTH-1:0] first_err_addr_o,
    output logic               first_err_valid_o,
    output logic               timeout_o
);

    localparam logic [A_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ERR_W-1:0]   ERR_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [ERR_W-1:0]   err_d;
    logic [A_WIDTH-1:0] fea_d;
    logic               fev_d;
    logic               exp_bit;
    logic               mismatch;

`ifdef LUTRAM_CHK_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              to_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // Expected pattern bit and compare result for the current address
    assign exp_bit  = addr_q[0] ^ INVERT;
    assign mismatch = sample_i && (q_i != exp_bit);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and result datapath
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_count_o;
        fea_d   = first_err_addr_o;
        fev_d   = first_err_valid_o;
`ifdef LUTRAM_CHK_TIMEOUT_EN
        wait_d  = '0;
        to_d    = timeout_o;
`endif

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                err_d  = '0;
                fea_d  = '0;
                fev_d  = 1'b0;
`ifdef LUTRAM_CHK_TIMEOUT_EN
                to_d   = 1'b0;
`endif
                if (start_i) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (sample_i) begin
                    addr_d = addr_q + A_WIDTH'(1);
                    if (mismatch) begin
                        if (err_count_o != ERR_MAX) begin
                            err_d = err_count_o + ERR_W'(1);
                        end
                        if (!first_err_valid_o) begin
                            fea_d = addr_q;
                            fev_d = 1'b1;
                        end
                    end
                    // err_count never wraps, so non-zero means an earlier miss
                    if (addr_q == ADDR_LAST) begin
                        state_d = (mismatch || (err_count_o != '0)) ? S_FAIL : S_PASS;
                    end
`ifdef LUTRAM_CHK_TIMEOUT_EN
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAIL;
                    to_d    = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
`endif
                end
            end

            S_PASS, S_FAIL: begin
                if (start_i) begin
                    state_d = S_CHECK;
                    addr_d  = '0;
                    err_d   = '0;
                    fea_d   = '0;
                    fev_d   = 1'b0;
`ifdef LUTRAM_CHK_TIMEOUT_EN
                    to_d    = 1'b0;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result and status registers; status flags decode the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q            <= '0;
            err_count_o       <= '0;
            first_err_addr_o  <= '0;
            first_err_valid_o <= 1'b0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            pass_o            <= 1'b0;
        end else begin
            addr_q            <= addr_d;
            err_count_o       <= err_d;
            first_err_addr_o  <= fea_d;
            first_err_valid_o <= fev_d;
            busy_o            <= (state_d == S_CHECK);
            done_o            <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass_o            <= (state_d == S_PASS);
        end
    end

`ifdef LUTRAM_CHK_TIMEOUT_EN
    // Watchdog: cycles since entry to CHECK or the last sample
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q    <= '0;
            timeout_o <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_o <= to_d;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/lutram_readback_checker.md
Name: lutram_readback_checker

Overview:
- Receive-side partner of the LUTRAM primitive test harnesses: consumes the serial read-back bit stream (one bit per address, ascending) produced during the READ sweep.
- Compares each bit against the expected written pattern and counts mismatches. Captures the first failing address and reports pass/fail for LEDs or an ILA.
- Runs in the harness's divided clock domain, alongside the DUT.

Parameters:
- A_WIDTH, 7, address bits of the LUTRAM under test; sweep length is 2**A_WIDTH samples.
- ERR_W, 8, width of the saturating mismatch counter.
- INVERT, 1'b0, expected bit = addr[0] ^ INVERT.
- TIMEOUT, 1024, max clk_i cycles between samples in CHECK (used only with the optional feature).

Ports:
- clk_i  input  1  check clock (the harness divided clock).
- rst_ni  input  1  reset, asynchronous assert, active-low.
- start_i  input  1  begin a check sweep (level or pulse; sampled each cycle).
- sample_i  input  1  strobe: q_i holds the read data for the current address this cycle.
- q_i  input  1  read-back data bit from the RAM output.
- busy_o  output  1  high while in CHECK.
- done_o  output  1  high while in PASS or FAIL.
- pass_o  output  1  high only in PASS.
- err_count_o  output  ERR_W  mismatches seen in the current/last sweep, saturating.
- first_err_addr_o  output  A_WIDTH  address of the first mismatch.
- first_err_valid_o  output  1  first_err_addr_o is meaningful.
- timeout_o  output  1  sweep aborted by watchdog (tied 0 without the optional feature).

Behaviour:
- One clock (clk_i). Reset is asynchronous, active-low (rst_ni).
- Reset state:
  - state=IDLE, addr=0.
  - busy_o, done_o, pass_o, first_err_valid_o and timeout_o = 0.
  - err_count_o=0 and first_err_addr_o=0.
- All outputs are registered; the effect of a sample is visible the cycle after sample_i.
- FSM states:
  - IDLE:
    - start_i=1 -> CHECK.
    - Clears addr, err_count, first_err_addr, first_err_valid and timeout.
    - sample_i is ignored.
  - CHECK:
    - On sample_i: exp = addr[0]^INVERT; mismatch = q_i != exp.
    - On mismatch: err_count += 1, saturating at all-ones. If first_err_valid=0, latch first_err_addr=addr and set first_err_valid.
    - addr increments by 1 per sample.
    - start_i is ignored in CHECK.
  - End of sweep:
    - Triggered by a sample with addr == 2**A_WIDTH-1.
    - -> PASS if no mismatch occurred in the whole sweep, including this last sample; otherwise -> FAIL.
    - addr wraps to 0.
  - PASS/FAIL:
    - Hold all results.
    - sample_i is ignored.
    - start_i=1 -> CHECK, clearing results the same way as IDLE->CHECK.
  - Illegal state encoding -> IDLE on the next clock.
- No sample_i cycles: the FSM waits in CHECK indefinitely (without the optional feature).
- Gaps: sample_i need not be contiguous; gaps of any length are legal.
- Asynchronous reset mid-sweep: immediate return to reset values; the next sweep needs a new start_i.
- Saturation: err_count holds at 2**ERR_W-1; further mismatches still force FAIL.

Optional Feature:
- Macro: LUTRAM_CHK_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to CHECK and on each sample_i, and increments on every other CHECK cycle.
  - When the counter reaches TIMEOUT-1 without a sample: -> FAIL, timeout_o=1.
  - err_count and first_err values are held as they were.
  - timeout_o clears on the next start_i.
- Undefined: no wait counter; timeout_o is tied 0; CHECK waits forever.

Test Plan:
- Clean sweep: reset, start_i pulse, 128 samples with q_i=addr[0] -> busy_o for the sweep; then done_o=1, pass_o=1, err_count_o=0, first_err_valid_o=0.
- Single fault: as the clean sweep but q_i inverted at addr 37 only -> FAIL, err_count_o=1, first_err_addr_o=37, first_err_valid_o=1.
- Saturation with ERR_W=4: all 128 samples inverted -> err_count_o=15, first_err_addr_o=0, FAIL; a fault on only the last sample (addr 127) also -> FAIL.
- Gapped strobes: insert 0-5 idle cycles randomly between samples and assert start_i during CHECK -> same result as contiguous; start_i has no effect mid-sweep.
- Reset and restart:
  - rst_ni low after sample 60 -> all outputs 0 asynchronously.
  - New start_i followed by a clean sweep -> PASS.
  - start_i from FAIL clears err_count_o to 0 one cycle later.
- Timeout (LUTRAM_CHK_TIMEOUT_EN, TIMEOUT=16): stop strobes after 10 samples -> FAIL and timeout_o=1 16 cycles after the last sample; with the macro undefined, busy_o stays 1.
